// File: rtl/uart_peek_pkg.sv
// Shared opcode/status encodings and FSM state type for the UART peek bridge.
package uart_peek_pkg;

    localparam logic [7:0] OP_READ_ONE   = 8'h01;
    localparam logic [7:0] OP_READ_BURST = 8'h02;
    localparam logic [7:0] OP_SWEEP      = 8'h03;

    localparam logic [7:0] ST_OK         = 8'h00;
    localparam logic [7:0] ST_BAD_OP     = 8'hEE;
    localparam logic [7:0] ST_BAD_ID     = 8'hE1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARGS,
        S_STATUS,
        S_ISSUE,
        S_WAIT,
        S_CAPTURE,
        S_SEND,
        S_NEXT
    } state_e;

endpackage

// File: rtl/word_serializer.sv
// Loads a W-bit word and emits load_nbytes bytes LSB-first over a
// valid/ready byte interface; done pulses as the last byte is accepted.
module word_serializer #(
    parameter  int W    = 32,
    localparam int NB   = W / 8,
    localparam int NB_W = $clog2(NB + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic [W-1:0]    load_data,
    input  logic [NB_W-1:0] load_nbytes,
    output logic [7:0]      tx_data,
    output logic            tx_valid,
    input  logic            tx_ready,
    output logic            done
);

    logic [W-1:0]    shreg_q, shreg_d;
    logic [NB_W-1:0] left_q, left_d;
    logic            valid_q, valid_d;

    // Shift out on each accepted byte; a new word is only taken when idle.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        shreg_d = shreg_q;
        left_d  = left_q;
        valid_d = valid_q;
        done    = 1'b0;
        if (valid_q && tx_ready) begin
            shreg_d = shreg_q >> 8;
            left_d  = left_q - NB_W'(1);
            if (left_q == NB_W'(1)) begin
                valid_d = 1'b0;
                done    = 1'b1;
            end
        end else if (load && !valid_q) begin
            shreg_d = load_data;
            left_d  = load_nbytes;
            valid_d = (load_nbytes != '0);
        end
    end

    // Serializer state register; reset clears any byte in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            shreg_q <= '0;
            left_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            shreg_q <= shreg_d;
            left_q  <= left_d;
            valid_q <= valid_d;
        end
    end

    // tx_data comes straight from the shift register, so it holds while stalled.
    assign tx_data  = shreg_q[7:0];
    assign tx_valid = valid_q;

endmodule

// File: rtl/uart_peek_bridge.sv
// Host-driven debug bridge: parses UART commands, issues peek reads and
// streams a status byte followed by data words LSB-first back over UART.
module uart_peek_bridge
    import uart_peek_pkg::*;
#(
    parameter int DATA_W         = 32,
    parameter int ADDR_W         = 32,
    parameter int ID_W           = 4,
    parameter int NODES          = 16,
    parameter int WORDS_PER_NODE = 1024,
    parameter int PEEK_LAT       = 1,
    parameter int RX_TIMEOUT     = 100000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic [ID_W-1:0]   peek_id,
    output logic [ADDR_W-1:0] peek_addr,
    input  logic [DATA_W-1:0] peek_data,
    output logic              busy,
    output logic              err,
    output logic              rx_drop
);

    localparam int A      = ADDR_W / 8;
    localparam int TOTAL  = NODES * WORDS_PER_NODE;
    localparam int CNT_W  = ($clog2(TOTAL + 1) > 16) ? $clog2(TOTAL + 1) : 16;
    localparam int TMO_W  = $clog2(RX_TIMEOUT + 1);
    localparam int LAT_W  = $clog2(PEEK_LAT + 1);
    localparam int NB_W   = $clog2(DATA_W / 8 + 1);

    state_e            state_q, state_d;
    logic [7:0]        op_q, op_d;
    logic [7:0]        arg_idx_q, arg_idx_d;
    logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
    logic [ID_W-1:0]   cur_id_q, cur_id_d;
    logic              bad_id_q, bad_id_d;
    logic [7:0]        cnt_lo_q, cnt_lo_d;
    logic [CNT_W-1:0]  rem_q, rem_d;
    logic [TMO_W-1:0]  timer_q, timer_d;
    logic [LAT_W-1:0]  wait_q, wait_d;
    logic [ID_W-1:0]   peek_id_q, peek_id_d;
    logic [ADDR_W-1:0] peek_addr_q, peek_addr_d;

    logic              ser_load;
    logic [DATA_W-1:0] ser_data;
    logic [NB_W-1:0]   ser_nbytes;
    logic              ser_done;

    logic              id_bad_rx;
    logic              bad_now;
    logic [7:0]        last_idx;

    assign id_bad_rx = ({1'b0, rx_data} >= 9'(NODES));
    assign bad_now   = (arg_idx_q == 8'(A)) ? id_bad_rx : bad_id_q;
    assign last_idx  = (op_q == OP_READ_ONE) ? 8'(A) : 8'(A + 2);

    // Command parser, peek sequencer and response control.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        arg_idx_d   = arg_idx_q;
        cur_addr_d  = cur_addr_q;
        cur_id_d    = cur_id_q;
        bad_id_d    = bad_id_q;
        cnt_lo_d    = cnt_lo_q;
        rem_d       = rem_q;
        timer_d     = timer_q;
        wait_d      = wait_q;
        peek_id_d   = peek_id_q;
        peek_addr_d = peek_addr_q;
        ser_load    = 1'b0;
        ser_data    = '0;
        ser_nbytes  = '0;
        err         = 1'b0;
        rx_drop     = rx_valid && (state_q != S_IDLE) && (state_q != S_ARGS);

        case (state_q)
            S_IDLE: begin
                if (rx_valid) begin
                    op_d      = rx_data;
                    arg_idx_d = '0;
                    timer_d   = '0;
                    bad_id_d  = 1'b0;
                    case (rx_data)
                        OP_READ_ONE, OP_READ_BURST: state_d = S_ARGS;
                        OP_SWEEP: begin
                            cur_addr_d = '0;
                            cur_id_d   = '0;
                            rem_d      = CNT_W'(TOTAL);
                            ser_load   = 1'b1;
                            ser_data   = DATA_W'(ST_OK);
                            ser_nbytes = NB_W'(1);
                            state_d    = S_STATUS;
                        end
                        default: begin
                            err        = 1'b1;
                            rem_d      = '0;
                            ser_load   = 1'b1;
                            ser_data   = DATA_W'(ST_BAD_OP);
                            ser_nbytes = NB_W'(1);
                            state_d    = S_STATUS;
                        end
                    endcase
                end
            end

            S_ARGS: begin
                if (timer_q == TMO_W'(RX_TIMEOUT - 1)) begin
                    // Stale partial command: discard it, including any byte arriving now.
                    err     = 1'b1;
                    rx_drop = rx_valid;
                    state_d = S_IDLE;
                end else if (rx_valid) begin
                    timer_d   = '0;
                    arg_idx_d = arg_idx_q + 8'd1;
                    if (arg_idx_q < 8'(A)) begin
                        cur_addr_d = (cur_addr_q >> 8) | (ADDR_W'(rx_data) << (ADDR_W - 8));
                    end else if (arg_idx_q == 8'(A)) begin
                        cur_id_d = rx_data[ID_W-1:0];
                        bad_id_d = id_bad_rx;
                    end else begin
                        cnt_lo_d = rx_data;
                    end
                    if (arg_idx_q == last_idx) begin
                        ser_load   = 1'b1;
                        ser_nbytes = NB_W'(1);
                        state_d    = S_STATUS;
                        if (bad_now) begin
                            err      = 1'b1;
                            rem_d    = '0;
                            ser_data = DATA_W'(ST_BAD_ID);
                        end else begin
                            ser_data = DATA_W'(ST_OK);
                            rem_d    = (op_q == OP_READ_ONE) ? CNT_W'(1)
                                                             : CNT_W'({rx_data, cnt_lo_q});
                        end
                    end
                end else begin
                    timer_d = timer_q + TMO_W'(1);
                end
            end

            S_STATUS: begin
                if (ser_done) state_d = (rem_q == '0) ? S_IDLE : S_ISSUE;
            end

            S_ISSUE: begin
                peek_id_d   = cur_id_q;
                peek_addr_d = cur_addr_q;
                wait_d      = '0;
                state_d     = S_WAIT;
            end

            S_WAIT: begin
                if (wait_q == LAT_W'(PEEK_LAT - 1)) state_d = S_CAPTURE;
                else                                 wait_d  = wait_q + LAT_W'(1);
            end

            S_CAPTURE: begin
                ser_load   = 1'b1;
                ser_data   = peek_data;
                ser_nbytes = NB_W'(DATA_W / 8);
                rem_d      = rem_q - CNT_W'(1);
                if (cur_addr_q == ADDR_W'(WORDS_PER_NODE - 1)) begin
                    cur_addr_d = '0;
                    cur_id_d   = (cur_id_q == ID_W'(NODES - 1)) ? '0 : cur_id_q + ID_W'(1);
                end else begin
                    cur_addr_d = cur_addr_q + ADDR_W'(1);
                end
                state_d = S_SEND;
            end

            S_SEND: begin
                if (ser_done) state_d = S_NEXT;
            end

            S_NEXT: begin
                state_d = (rem_q == '0) ? S_IDLE : S_ISSUE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any command or response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            op_q        <= '0;
            arg_idx_q   <= '0;
            cur_addr_q  <= '0;
            cur_id_q    <= '0;
            bad_id_q    <= 1'b0;
            cnt_lo_q    <= '0;
            rem_q       <= '0;
            timer_q     <= '0;
            wait_q      <= '0;
            peek_id_q   <= '0;
            peek_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            arg_idx_q   <= arg_idx_d;
            cur_addr_q  <= cur_addr_d;
            cur_id_q    <= cur_id_d;
            bad_id_q    <= bad_id_d;
            cnt_lo_q    <= cnt_lo_d;
            rem_q       <= rem_d;
            timer_q     <= timer_d;
            wait_q      <= wait_d;
            peek_id_q   <= peek_id_d;
            peek_addr_q <= peek_addr_d;
        end
    end

    word_serializer #(.W(DATA_W)) u_ser (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (ser_load),
        .load_data   (ser_data),
        .load_nbytes (ser_nbytes),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .done        (ser_done)
    );

    assign peek_id   = peek_id_q;
    assign peek_addr = peek_addr_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_peek_bridge.sv
// Directed bench for uart_peek_bridge: instance A uses the full-size mesh
// with a short RX timeout, instance B a tiny mesh with PEEK_LAT=3 for sweeps.
module tb_uart_peek_bridge;

    localparam int TMO_A = 64;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    // ---------------- instance A signals
    logic [7:0]  rx_data_a  = '0;
    logic        rx_valid_a = 1'b0;
    logic [7:0]  tx_data_a;
    logic        tx_valid_a;
    logic        tx_ready_a = 1'b1;
    logic [3:0]  peek_id_a;
    logic [31:0] peek_addr_a;
    logic [31:0] peek_data_a = '0;
    logic        busy_a, err_a, rx_drop_a;

    // ---------------- instance B signals
    logic [7:0]  rx_data_b  = '0;
    logic        rx_valid_b = 1'b0;
    logic [7:0]  tx_data_b;
    logic        tx_valid_b;
    logic        tx_ready_b = 1'b1;
    logic [3:0]  peek_id_b;
    logic [31:0] peek_addr_b;
    logic [31:0] peek_data_b = '0;
    logic        busy_b, err_b, rx_drop_b;

    uart_peek_bridge #(.NODES(16), .WORDS_PER_NODE(1024), .PEEK_LAT(1), .RX_TIMEOUT(TMO_A)) dut_a (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data_a), .rx_valid(rx_valid_a),
        .tx_data(tx_data_a), .tx_valid(tx_valid_a), .tx_ready(tx_ready_a),
        .peek_id(peek_id_a), .peek_addr(peek_addr_a), .peek_data(peek_data_a),
        .busy(busy_a), .err(err_a), .rx_drop(rx_drop_a)
    );

    uart_peek_bridge #(.NODES(2), .WORDS_PER_NODE(4), .PEEK_LAT(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data_b), .rx_valid(rx_valid_b),
        .tx_data(tx_data_b), .tx_valid(tx_valid_b), .tx_ready(tx_ready_b),
        .peek_id(peek_id_b), .peek_addr(peek_addr_b), .peek_data(peek_data_b),
        .busy(busy_b), .err(err_b), .rx_drop(rx_drop_b)
    );

    // Core memory contents: node 3 addr 5 preloaded, everything else a tagged pattern.
    function automatic logic [31:0] mem_val(input logic [3:0] id, input logic [31:0] addr);
        if (id == 4'd3 && addr == 32'd5) return 32'hDEADBEEF;
        return {4'hC, id, 8'h5A, addr[15:0]};
    endfunction

    // Peek memories: A has 1 cycle of latency, B a 3-deep pipeline.
    logic [31:0] pb1 = '0, pb2 = '0;
    always @(posedge clk) begin
        peek_data_a <= mem_val(peek_id_a, peek_addr_a);
        pb1         <= mem_val(peek_id_b, peek_addr_b);
        pb2         <= pb1;
        peek_data_b <= pb2;
    end

    // tx_ready for A: always high, or high one cycle in three when stalling.
    int ready_mode = 0;
    int cyc        = 0;
    always begin
        @(posedge clk);
        #1;
        cyc++;
        tx_ready_a = (ready_mode == 0) ? 1'b1 : ((cyc % 3) == 0);
    end

    // Monitors sampled on the falling edge.
    logic [7:0]  got_a[$];
    logic [7:0]  got_b[$];
    int          err_cnt_a = 0, drop_cnt_a = 0, peek_chg_a = 0, stall_viol_a = 0;
    logic        prev_stall = 1'b0;
    logic [7:0]  prev_data  = '0;
    logic [31:0] last_peek_addr_a = '0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (tx_valid_a && tx_ready_a) got_a.push_back(tx_data_a);
            if (tx_valid_b && tx_ready_b) got_b.push_back(tx_data_b);
            if (err_a) err_cnt_a++;
            if (rx_drop_a) drop_cnt_a++;
            if (peek_addr_a != last_peek_addr_a) peek_chg_a++;
            last_peek_addr_a = peek_addr_a;
            if (prev_stall && (!tx_valid_a || tx_data_a != prev_data)) stall_viol_a++;
            prev_stall = tx_valid_a && !tx_ready_a;
            prev_data  = tx_data_a;
        end
    end

    // ---------------- stimulus helpers
    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic send_a(input logic [7:0] b);
        rx_data_a  = b;
        rx_valid_a = 1'b1;
        @(posedge clk);
        #1;
        rx_valid_a = 1'b0;
    endtask

    task automatic send_b(input logic [7:0] b);
        rx_data_b  = b;
        rx_valid_b = 1'b1;
        @(posedge clk);
        #1;
        rx_valid_b = 1'b0;
    endtask

    task automatic send_read_one_a(input logic [31:0] addr, input logic [7:0] id);
        send_a(8'h01);
        for (int i = 0; i < 4; i++) send_a(addr[8*i +: 8]);
        send_a(id);
    endtask

    task automatic send_burst_a(input logic [31:0] addr, input logic [7:0] id, input logic [15:0] cnt);
        send_a(8'h02);
        for (int i = 0; i < 4; i++) send_a(addr[8*i +: 8]);
        send_a(id);
        send_a(cnt[7:0]);
        send_a(cnt[15:8]);
    endtask

    task automatic wait_idle_a(input int max_cyc, output bit ok);
        int n = 0;
        @(negedge clk);
        while (busy_a && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        ok = !busy_a;
        sync();
    endtask

    task automatic wait_idle_b(input int max_cyc, output bit ok);
        int n = 0;
        @(negedge clk);
        while (busy_b && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        ok = !busy_b;
        sync();
    endtask

    // ---------------- tests
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total += 7;
        if (tx_valid_a !== 1'b0) $display("FAIL reset_tx_valid: got %b want 0", tx_valid_a); else passed++;
        if (tx_data_a !== 8'h00) $display("FAIL reset_tx_data: got %h want 00", tx_data_a); else passed++;
        if (peek_id_a !== 4'h0) $display("FAIL reset_peek_id: got %h want 0", peek_id_a); else passed++;
        if (peek_addr_a !== 32'h0) $display("FAIL reset_peek_addr: got %h want 0", peek_addr_a); else passed++;
        if (busy_a !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy_a); else passed++;
        if (err_a !== 1'b0) $display("FAIL reset_err: got %b want 0", err_a); else passed++;
        if (rx_drop_a !== 1'b0) $display("FAIL reset_rx_drop: got %b want 0", rx_drop_a); else passed++;
        rst_n = 1'b1;
        repeat (2) sync();
    endtask

    task automatic test_read_one();
        logic [7:0] exp [5] = '{8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        int  base = got_a.size();
        int  e0   = err_cnt_a;
        bit  ok;
        send_read_one_a(32'd5, 8'd3);
        total++;
        if (tx_valid_a !== 1'b1 || tx_data_a !== 8'h00)
            $display("FAIL read_one_status_timing: got valid=%b data=%h want valid=1 data=00", tx_valid_a, tx_data_a);
        else passed++;
        wait_idle_a(200, ok);
        total++;
        if (!ok) $display("FAIL read_one_done: busy still high after 200 cycles, want 0"); else passed++;
        total++;
        if (got_a.size() - base != 5) $display("FAIL read_one_len: got %0d want 5", got_a.size() - base); else passed++;
        for (int i = 0; i < 5; i++) begin
            total++;
            if (got_a[base + i] !== exp[i]) $display("FAIL read_one_byte%0d: got %h want %h", i, got_a[base + i], exp[i]);
            else passed++;
        end
        total++;
        if (err_cnt_a - e0 != 0) $display("FAIL read_one_err: got %0d pulses want 0", err_cnt_a - e0); else passed++;
    endtask

    task automatic test_burst();
        logic [7:0] exp [13] = '{8'h00, 8'hFE, 8'h03, 8'h5A, 8'hC2, 8'hFF, 8'h03, 8'h5A, 8'hC2,
                                 8'h00, 8'h00, 8'h5A, 8'hC3};
        int  base = got_a.size();
        bit  ok;
        send_burst_a(32'd1022, 8'd2, 16'd3);
        wait_idle_a(400, ok);
        total++;
        if (!ok) $display("FAIL burst_done: busy still high after 400 cycles, want 0"); else passed++;
        total++;
        if (got_a.size() - base != 13) $display("FAIL burst_len: got %0d want 13", got_a.size() - base); else passed++;
        for (int i = 0; i < 13; i++) begin
            total++;
            if (got_a[base + i] !== exp[i]) $display("FAIL burst_byte%0d: got %h want %h", i, got_a[base + i], exp[i]);
            else passed++;
        end
        total++;
        if (peek_id_a !== 4'd3 || peek_addr_a !== 32'd0)
            $display("FAIL burst_wrap_peek: got id=%h addr=%h want id=3 addr=0", peek_id_a, peek_addr_a);
        else passed++;
    endtask

    task automatic test_bad_cmds();
        int  base = got_a.size();
        int  e0   = err_cnt_a;
        int  p0;
        bit  ok;
        send_a(8'h7F);
        wait_idle_a(50, ok);
        total += 3;
        if (got_a.size() - base != 1) $display("FAIL bad_op_len: got %0d want 1", got_a.size() - base); else passed++;
        if (got_a[base] !== 8'hEE) $display("FAIL bad_op_status: got %h want ee", got_a[base]); else passed++;
        if (err_cnt_a - e0 != 1) $display("FAIL bad_op_err: got %0d pulses want 1", err_cnt_a - e0); else passed++;

        base = got_a.size();
        e0   = err_cnt_a;
        p0   = peek_chg_a;
        send_read_one_a(32'd5, 8'h10);
        wait_idle_a(50, ok);
        total += 4;
        if (got_a.size() - base != 1) $display("FAIL bad_id_len: got %0d want 1", got_a.size() - base); else passed++;
        if (got_a[base] !== 8'hE1) $display("FAIL bad_id_status: got %h want e1", got_a[base]); else passed++;
        if (err_cnt_a - e0 != 1) $display("FAIL bad_id_err: got %0d pulses want 1", err_cnt_a - e0); else passed++;
        if (peek_chg_a - p0 != 0) $display("FAIL bad_id_peek: got %0d addr changes want 0", peek_chg_a - p0); else passed++;
    endtask

    task automatic test_stall();
        logic [7:0] exp [5] = '{8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        int  base = got_a.size();
        int  v0   = stall_viol_a;
        bit  ok;
        ready_mode = 1;
        send_read_one_a(32'd5, 8'd3);
        wait_idle_a(300, ok);
        ready_mode = 0;
        sync();
        total += 2;
        if (got_a.size() - base != 5) $display("FAIL stall_len: got %0d want 5", got_a.size() - base); else passed++;
        if (stall_viol_a - v0 != 0) $display("FAIL stall_hold: got %0d changes while stalled want 0", stall_viol_a - v0); else passed++;
        for (int i = 0; i < 5; i++) begin
            total++;
            if (got_a[base + i] !== exp[i]) $display("FAIL stall_byte%0d: got %h want %h", i, got_a[base + i], exp[i]);
            else passed++;
        end
    endtask

    task automatic test_timeout();
        int  base = got_a.size();
        int  e0   = err_cnt_a;
        bit  ok;
        send_a(8'h01);
        send_a(8'h05);
        send_a(8'h00);
        wait_idle_a(TMO_A + 20, ok);
        total += 3;
        if (!ok) $display("FAIL timeout_idle: busy still high after %0d cycles, want 0", TMO_A + 20); else passed++;
        if (err_cnt_a - e0 != 1) $display("FAIL timeout_err: got %0d pulses want 1", err_cnt_a - e0); else passed++;
        if (got_a.size() - base != 0) $display("FAIL timeout_tx: got %0d bytes want 0", got_a.size() - base); else passed++;
        base = got_a.size();
        send_read_one_a(32'd5, 8'd3);
        wait_idle_a(200, ok);
        total += 2;
        if (got_a.size() - base != 5) $display("FAIL after_timeout_len: got %0d want 5", got_a.size() - base); else passed++;
        if (got_a[base + 1] !== 8'hEF) $display("FAIL after_timeout_byte1: got %h want ef", got_a[base + 1]); else passed++;
    endtask

    task automatic test_rx_drop();
        logic [7:0] exp [13] = '{8'h00, 8'hFE, 8'h03, 8'h5A, 8'hC2, 8'hFF, 8'h03, 8'h5A, 8'hC2,
                                 8'h00, 8'h00, 8'h5A, 8'hC3};
        int  base = got_a.size();
        int  d0   = drop_cnt_a;
        int  stray = 0;
        bit  ok;
        send_burst_a(32'd1022, 8'd2, 16'd3);
        for (int k = 0; k < 3; k++) begin
            repeat (3) @(posedge clk);
            #1;
            if (busy_a) stray++;
            send_a(8'h01);
        end
        wait_idle_a(400, ok);
        total += 3;
        if (stray != 3) $display("FAIL rx_drop_window: got %0d bytes sent while busy want 3", stray); else passed++;
        if (drop_cnt_a - d0 != 3) $display("FAIL rx_drop_count: got %0d pulses want 3", drop_cnt_a - d0); else passed++;
        if (got_a.size() - base != 13) $display("FAIL rx_drop_len: got %0d want 13", got_a.size() - base); else passed++;
        for (int i = 0; i < 13; i++) begin
            total++;
            if (got_a[base + i] !== exp[i]) $display("FAIL rx_drop_byte%0d: got %h want %h", i, got_a[base + i], exp[i]);
            else passed++;
        end
    endtask

    task automatic test_sweep();
        int          base = got_b.size();
        logic [31:0] word;
        logic [31:0] want;
        bit          ok;
        send_b(8'h03);
        wait_idle_b(1000, ok);
        total += 3;
        if (!ok) $display("FAIL sweep_done: busy still high after 1000 cycles, want 0"); else passed++;
        if (got_b.size() - base != 33) $display("FAIL sweep_len: got %0d want 33", got_b.size() - base); else passed++;
        if (got_b[base] !== 8'h00) $display("FAIL sweep_status: got %h want 00", got_b[base]); else passed++;
        for (int w = 0; w < 8; w++) begin
            word = {got_b[base + 4*w + 4], got_b[base + 4*w + 3], got_b[base + 4*w + 2], got_b[base + 4*w + 1]};
            want = mem_val(4'(w / 4), 32'(w % 4));
            total++;
            if (word !== want) $display("FAIL sweep_word%0d: got %h want %h", w, word, want); else passed++;
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] exp [5] = '{8'h00, 8'h02, 8'h00, 8'h5A, 8'hC1};
        int  base = got_b.size();
        int  n = 0;
        bit  ok;
        send_b(8'h03);
        while (got_b.size() < base + 6 && n < 200) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (got_b.size() < base + 6) $display("FAIL reset_mid_progress: got %0d bytes want >=6", got_b.size() - base); else passed++;
        sync();
        rst_n = 1'b0;
        #1;
        total += 2;
        if (tx_valid_b !== 1'b0) $display("FAIL reset_mid_tx_valid: got %b want 0", tx_valid_b); else passed++;
        if (busy_b !== 1'b0) $display("FAIL reset_mid_busy: got %b want 0", busy_b); else passed++;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        sync();
        base = got_b.size();
        send_b(8'h01);
        send_b(8'h02);
        send_b(8'h00);
        send_b(8'h00);
        send_b(8'h00);
        send_b(8'h01);
        wait_idle_b(200, ok);
        total++;
        if (got_b.size() - base != 5) $display("FAIL post_reset_len: got %0d want 5", got_b.size() - base); else passed++;
        for (int i = 0; i < 5; i++) begin
            total++;
            if (got_b[base + i] !== exp[i]) $display("FAIL post_reset_byte%0d: got %h want %h", i, got_b[base + i], exp[i]);
            else passed++;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_read_one();
        test_burst();
        test_bad_cmds();
        test_stall();
        test_timeout();
        test_rx_drop();
        test_sweep();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/uart_peek_bridge.md
Name: uart_peek_bridge

Overview:
Command-driven debug bridge between the UART byte stream and the NoC-with-cores peek port; replaces the free-running address sweep with host-controlled reads.
Parses opcode/argument bytes from UART RX, issues peek reads with configurable latency, and serialises status plus data words LSB-first onto UART TX.
Supports single read, burst read with node wrap-around, and full-mesh sweep; generalised in data/address width, node count and memory depth.

Parameters:
DATA_W, 32, peek data width; multiple of 8
ADDR_W, 32, peek address width; multiple of 8
ID_W, 4, node id width; at most 8
NODES, 16, number of cores; at most 2**ID_W
WORDS_PER_NODE, 1024, words per core memory
PEEK_LAT, 1, cycles from peek_id/peek_addr change to valid peek_data; at least 1
RX_TIMEOUT, 100000, idle cycles between command bytes before discarding a partial command

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
rx_data  in  8  received byte
rx_valid  in  1  one-cycle strobe per received byte
tx_data  out  8  byte to transmit
tx_valid  out  1  byte valid; held until accepted
tx_ready  in  1  transmitter can accept; transfer on tx_valid&&tx_ready
peek_id  out  ID_W  node select
peek_addr  out  ADDR_W  word address
peek_data  in  DATA_W  read data
busy  out  1  high outside IDLE
err  out  1  one-cycle pulse on bad opcode, bad id or timeout
rx_drop  out  1  one-cycle pulse when an rx byte is discarded while responding

Behaviour:
- Reset values: tx_data=0, tx_valid=0, peek_id=0, peek_addr=0, busy=0, err=0, rx_drop=0; FSM=IDLE; all counters 0. Asserting reset mid-command or mid-response aborts immediately with no partial byte.
- Multi-byte fields are LSB first: A=ADDR_W/8 address bytes, 1 id byte, 2 count bytes.
- Opcode 0x01 READ_ONE: args addr, id. Response: 0x00, then one word.
- Opcode 0x02 READ_BURST: args addr, id, count. Response: 0x00, then count words. count=0 returns the status byte only.
- Opcode 0x03 SWEEP: no args. Response: 0x00, then NODES*WORDS_PER_NODE words, id-major starting at id 0, addr 0.
- Any other opcode: response 0xEE only, plus an err pulse.
- id>=NODES: response 0xE1 only, plus an err pulse. No peek is issued.
- FSM states:
  - IDLE: wait for an opcode byte.
  - ARGS: collect argument bytes.
  - STATUS: send the status byte.
  - ISSUE: drive peek_id/peek_addr.
  - WAIT: PEEK_LAT cycles.
  - CAPTURE: latch peek_data.
  - SEND: DATA_W/8 bytes.
  - NEXT: advance or finish, then IDLE.
- Transitions:
  - Status tx_valid asserts the cycle after the last argument byte (after the opcode byte for SWEEP or a bad opcode).
  - Peek issue begins only after the status byte is accepted.
  - Captured word is stable across all SEND bytes; peek outputs may advance during SEND.
- Address advance:
  - Burst/sweep address increments by 1.
  - At WORDS_PER_NODE-1 the address wraps to 0 and the id increments, wrapping at NODES-1 to 0.
  - Address arithmetic is modulo 2**ADDR_W. A burst start address >= WORDS_PER_NODE is passed through unchanged and increments until the wrap comparison is met.
- TX handshake: tx_data/tx_valid must not change while tx_valid=1 and tx_ready=0. Back-to-back bytes are allowed when tx_ready stays high.
- RX handling:
  - In ARGS, the timeout counter resets on each rx_valid. Reaching RX_TIMEOUT discards the command, pulses err, returns to IDLE, and sends nothing.
  - rx_valid outside IDLE/ARGS drops the byte and pulses rx_drop the same cycle.
  - rx_valid coincident with the timeout cycle is dropped.

Decomposition:
- Package uart_peek_pkg:
  - opcode constants OP_READ_ONE, OP_READ_BURST, OP_SWEEP
  - status constants ST_OK=0x00, ST_BAD_OP=0xEE, ST_BAD_ID=0xE1
  - FSM state enum
- Sub-module word_serializer: captures DATA_W on load and emits DATA_W/8 bytes LSB-first with valid/ready and a done pulse. It is used for both the status byte and data words.

Test Plan:
- Preload node 3 addr 5 = 0xDEADBEEF. Send 01 05 00 00 00 03 with tx_ready=1. TX must be 00 EF BE AD DE, and busy must drop after the last byte.
- Send burst 02 FE 03 00 00 02 03 00 (addr 1022, id 2, count 3). TX must be status 00, then words (2,1022), (2,1023), (3,0).
- Send 0x7F. TX must be EE only, with one err pulse. Then send 01 with id 0x10 (NODES=16). TX must be E1 only, with an err pulse and no peek_addr activity.
- READ_ONE with tx_ready toggling 1-of-3 cycles. tx_data/tx_valid must hold while stalled, and exactly 5 bytes must be transferred in order.
- Send 01 05 00 then idle RX_TIMEOUT cycles. err must pulse, nothing is transmitted, and a following valid READ_ONE responds correctly. Send rx bytes during a burst response: rx_drop must pulse for each and the response must be unaffected.
- With PEEK_LAT=3 and NODES=2, WORDS_PER_NODE=4, run SWEEP. Exactly 1+8 words' bytes must be sent, with data matching each (id,addr) in order. Reset mid-sweep: tx_valid must be 0 and busy 0 immediately.
